// File: rtl/wb_write_queue_if.sv
// Bus bundle for wb_write_queue: producer handshakes, RF write port, decode lookups and status.
// The queue takes the slave modport; producers/RF/decode side take the master modport.
interface wb_write_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    logic                   alu_valid;
    logic                   alu_ready;
    logic [AW-1:0]          alu_addr;
    logic [DW-1:0]          alu_data;
    logic                   mem_valid;
    logic                   mem_ready;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_data;
    logic                   rf_wr_en;
    logic [AW-1:0]          rf_wr_addr;
    logic [DW-1:0]          rf_wr_data;
    logic [AW-1:0]          rs_addr;
    logic [AW-1:0]          rt_addr;
    logic                   rs_hit;
    logic                   rt_hit;
    logic [DW-1:0]          rs_fwd;
    logic [DW-1:0]          rt_fwd;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output rs_addr, rt_addr,
        input  alu_ready, mem_ready,
        input  rf_wr_en, rf_wr_addr, rf_wr_data,
        input  rs_hit, rt_hit, rs_fwd, rt_fwd,
        input  empty, count
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  rs_addr, rt_addr,
        output alu_ready, mem_ready,
        output rf_wr_en, rf_wr_addr, rf_wr_data,
        output rs_hit, rt_hit, rs_fwd, rt_fwd,
        output empty, count
    );
endinterface

// File: rtl/wb_write_queue.sv
// In-order write-back queue feeding the register file write port, one commit per cycle.
// Optional decode-stage forwarding of pending results is enabled by defining WB_BYPASS_EN.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input logic             clk,
    input logic             rst,
    wb_write_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] qAddr [DEPTH];
    logic [DW-1:0] qData [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] count;

    logic          full;
    logic          pushHs;
    logic          push;
    logic          pop;
    logic [AW-1:0] pushAddr;
    logic [DW-1:0] pushData;

    logic          vld_p1;
    logic [AW-1:0] wrAddr_p1;
    logic [DW-1:0] wrData_p1;

    // No pass-through: a pop in the same cycle never reopens a full queue.
    assign full          = (count == CW'(DEPTH));
    assign bus.mem_ready = !full;
    assign bus.alu_ready = !full && !bus.mem_valid;

    always_comb begin
        pushAddr = bus.alu_addr;
        pushData = bus.alu_data;
        if (bus.mem_valid) begin
            pushAddr = bus.mem_addr;
            pushData = bus.mem_data;
        end
    end

    // r0 writes complete their handshake but are dropped here.
    assign pushHs = (bus.mem_valid || bus.alu_valid) && !full;
    assign push   = pushHs && (pushAddr != '0);
    assign pop    = (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            qAddr[wrPtr] <= pushAddr;
            qData[wrPtr] <= pushData;
        end
    end

    // Queue -> output stage (_p1) boundary; the output stage drives the RF port directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            vld_p1    <= 1'b0;
            wrAddr_p1 <= '0;
            wrData_p1 <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            count  <= count + CW'(push) - CW'(pop);
            vld_p1 <= pop;
            if (pop) begin
                wrAddr_p1 <= qAddr[rdPtr];
                wrData_p1 <= qData[rdPtr];
            end
        end
    end

    assign bus.rf_wr_en   = vld_p1;
    assign bus.rf_wr_addr = wrAddr_p1;
    assign bus.rf_wr_data = wrData_p1;
    assign bus.count      = count;
    assign bus.empty      = (count == '0) && !vld_p1;

`ifdef WB_BYPASS_EN
    logic          rsHit;
    logic          rtHit;
    logic [DW-1:0] rsFwd;
    logic [DW-1:0] rtFwd;

    // Scan oldest to newest so the youngest match overwrites older ones.
    always_comb begin
        rsHit = 1'b0;
        rtHit = 1'b0;
        rsFwd = '0;
        rtFwd = '0;
        if (vld_p1 && (wrAddr_p1 == bus.rs_addr)) begin
            rsHit = 1'b1;
            rsFwd = wrData_p1;
        end
        if (vld_p1 && (wrAddr_p1 == bus.rt_addr)) begin
            rtHit = 1'b1;
            rtFwd = wrData_p1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && (qAddr[rdPtr + PW'(i)] == bus.rs_addr)) begin
                rsHit = 1'b1;
                rsFwd = qData[rdPtr + PW'(i)];
            end
            if ((CW'(i) < count) && (qAddr[rdPtr + PW'(i)] == bus.rt_addr)) begin
                rtHit = 1'b1;
                rtFwd = qData[rdPtr + PW'(i)];
            end
        end
        if (bus.rs_addr == '0) begin
            rsHit = 1'b0;
            rsFwd = '0;
        end
        if (bus.rt_addr == '0) begin
            rtHit = 1'b0;
            rtFwd = '0;
        end
    end

    assign bus.rs_hit = rsHit;
    assign bus.rt_hit = rtHit;
    assign bus.rs_fwd = rsFwd;
    assign bus.rt_fwd = rtFwd;
`else
    logic unusedLookup;
    assign unusedLookup = ^{bus.rs_addr, bus.rt_addr};

    assign bus.rs_hit = 1'b0;
    assign bus.rt_hit = 1'b0;
    assign bus.rs_fwd = '0;
    assign bus.rt_fwd = '0;
`endif
endmodule
